// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter: FSM states, requester ids and bus attributes.
package mem_arb_pkg;

    localparam int unsigned N_TMO_DEFAULT = 8;
    localparam int unsigned BUS_ADDR_W    = 32;
    localparam int unsigned BUS_DATA_W    = 32;

    typedef enum logic [2:0] {
        StIdle,
        StBusyIf,
        StBusyMem,
        StDoneIf,
        StDoneMem
    } arb_state_e;

    typedef enum logic {
        ReqIf,
        ReqMem
    } req_id_e;

    typedef struct packed {
        logic                  we;
        logic [3:0]            sel;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_attr_t;

    function automatic req_id_e state_owner(input arb_state_e s);
        return ((s == StBusyMem) || (s == StDoneMem)) ? ReqMem : ReqIf;
    endfunction

endpackage

// File: rtl/bus_timeout_timer.sv
// Counts bus wait cycles; expired_o flags the cycle whose increment reaches all-ones.
module bus_timeout_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_TMO = N_TMO_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [N_TMO-1:0] CntLast = ~N_TMO'(1);

    logic [N_TMO-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + N_TMO'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // 2**N_TMO-1 unacknowledged cycles have elapsed once this increment lands.
    assign expired_o = en_i & (cnt_q == CntLast);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data access; data wins ties,
// results are held while the pipeline stalls and hung cycles abort on timeout.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_ADDR = BUS_ADDR_W,
    parameter int unsigned N_DATA = BUS_DATA_W,
    parameter int unsigned N_TMO  = N_TMO_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_if_req,
    input  logic [N_ADDR-1:0] i_if_addr,
    output logic [N_DATA-1:0] o_if_rdata,
    output logic              o_if_done,
    output logic              o_if_streq,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [3:0]        i_mem_sel,
    input  logic [N_ADDR-1:0] i_mem_addr,
    input  logic [N_DATA-1:0] i_mem_wdata,
    output logic [N_DATA-1:0] o_mem_rdata,
    output logic              o_mem_done,
    output logic              o_mem_streq,
    output logic              o_err,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [3:0]        o_bus_sel,
    output logic [N_ADDR-1:0] o_bus_addr,
    output logic [N_DATA-1:0] o_bus_wdata,
    input  logic [N_DATA-1:0] i_bus_rdata,
    input  logic              i_bus_ack
);

    arb_state_e        state_q, state_d;
    bus_attr_t         bus_q, bus_d;
    logic              bus_req_q, bus_req_d;
    logic [N_DATA-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              flushed_q, flushed_d;
    logic              busy;
    logic              tmo_expired;

    assign busy = (state_q == StBusyIf) || (state_q == StBusyMem);

    bus_timeout_timer #(
        .N_TMO(N_TMO)
    ) u_timer (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clr_i    (~busy),
        .en_i     (busy & ~i_bus_ack),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        bus_req_d = bus_req_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        flushed_d = flushed_q;
        unique case (state_q)
            StIdle: begin
                flushed_d = 1'b0;
                if (i_mem_req) begin
                    state_d     = StBusyMem;
                    bus_req_d   = 1'b1;
                    err_d       = 1'b0;
                    bus_d.we    = i_mem_we;
                    bus_d.sel   = i_mem_sel;
                    bus_d.addr  = BUS_ADDR_W'(i_mem_addr);
                    bus_d.wdata = BUS_DATA_W'(i_mem_wdata);
                end else if (i_if_req && !i_flush) begin
                    state_d     = StBusyIf;
                    bus_req_d   = 1'b1;
                    err_d       = 1'b0;
                    bus_d.we    = 1'b0;
                    bus_d.sel   = 4'hF;
                    bus_d.addr  = BUS_ADDR_W'(i_if_addr);
                    bus_d.wdata = '0;
                end
            end
            StBusyIf, StBusyMem: begin
                // A flush seen at any point of the fetch cycle discards its result.
                if ((state_q == StBusyIf) && i_flush) begin
                    flushed_d = 1'b1;
                end
                if (i_bus_ack || tmo_expired) begin
                    bus_req_d = 1'b0;
                    err_d     = ~i_bus_ack;
                    rdata_d   = (i_bus_ack && !bus_q.we) ? i_bus_rdata : '0;
                    if (state_owner(state_q) == ReqMem) begin
                        state_d = StDoneMem;
                    end else if (flushed_d) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDoneIf;
                    end
                end
            end
            StDoneIf: begin
                if (!i_stall || !i_if_req || i_flush) begin
                    state_d = StIdle;
                end
            end
            StDoneMem: begin
                if (!i_stall || !i_mem_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            bus_q     <= '0;
            bus_req_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            bus_req_q <= bus_req_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            flushed_q <= flushed_d;
        end
    end

    assign o_if_done   = (state_q == StDoneIf);
    assign o_mem_done  = (state_q == StDoneMem);
    assign o_if_rdata  = o_if_done ? rdata_q : '0;
    assign o_mem_rdata = o_mem_done ? rdata_q : '0;
    assign o_err       = err_q & (o_if_done | o_mem_done);
    assign o_if_streq  = i_if_req & ~o_if_done;
    assign o_mem_streq = i_mem_req & ~o_mem_done;

    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_q.we;
    assign o_bus_sel   = bus_q.sel;
    assign o_bus_addr  = N_ADDR'(bus_q.addr);
    assign o_bus_wdata = N_DATA'(bus_q.wdata);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter: directed protocol cases, then randomized
// traffic against a word-memory reference model with a wait-state bus slave.
module tb_mem_bus_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst, i_stall, i_flush;
    logic        i_if_req, i_mem_req, i_mem_we;
    logic [31:0] i_if_addr, i_mem_addr, i_mem_wdata, i_bus_rdata;
    logic [3:0]  i_mem_sel;
    logic        i_bus_ack;
    logic [31:0] o_if_rdata, o_mem_rdata, o_bus_addr, o_bus_wdata;
    logic        o_if_done, o_if_streq, o_mem_done, o_mem_streq, o_err, o_bus_req, o_bus_we;
    logic [3:0]  o_bus_sel;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_if[$];
    exp_t        exp_mem[$];
    exp_t        mon_e;
    exp_t        e;
    logic [31:0] slave_mem[512];
    logic [31:0] ref_mem[512];
    int          slv_force = -1;
    int          slv_cnt, slv_wait;
    logic        rand_done = 1'b0;
    int          nreq, ndone;
    logic        found;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .N_ADDR(32),
        .N_DATA(32),
        .N_TMO (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_rdata (o_if_rdata),
        .o_if_done  (o_if_done),
        .o_if_streq (o_if_streq),
        .i_mem_req  (i_mem_req),
        .i_mem_we   (i_mem_we),
        .i_mem_sel  (i_mem_sel),
        .i_mem_addr (i_mem_addr),
        .i_mem_wdata(i_mem_wdata),
        .o_mem_rdata(o_mem_rdata),
        .o_mem_done (o_mem_done),
        .o_mem_streq(o_mem_streq),
        .o_err      (o_err),
        .o_bus_req  (o_bus_req),
        .o_bus_we   (o_bus_we),
        .o_bus_sel  (o_bus_sel),
        .o_bus_addr (o_bus_addr),
        .o_bus_wdata(o_bus_wdata),
        .i_bus_rdata(i_bus_rdata),
        .i_bus_ack  (i_bus_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Word-addressed slave: addr[11] set means unmapped (never acks).
    initial begin
        logic [8:0] sidx;
        i_bus_ack   = 1'b0;
        i_bus_rdata = '0;
        slv_cnt     = 0;
        slv_wait    = 0;
        forever begin
            cyc();
            i_bus_ack   = 1'b0;
            i_bus_rdata = '0;
            if (!o_bus_req) begin
                slv_cnt  = 0;
                slv_wait = (slv_force >= 0) ? slv_force : int'($urandom_range(0, 3));
            end else if (!o_bus_addr[11]) begin
                if (slv_cnt == slv_wait) begin
                    i_bus_ack = 1'b1;
                    sidx      = o_bus_addr[10:2];
                    if (o_bus_we) begin
                        slave_mem[sidx] = merge(slave_mem[sidx], o_bus_wdata, o_bus_sel);
                        i_bus_rdata     = $urandom;
                    end else begin
                        i_bus_rdata = slave_mem[sidx];
                    end
                    slv_cnt = 1000;
                end else begin
                    slv_cnt++;
                end
            end
        end
    end

    // Monitor: a result is retired on the cycle it is consumed (done and not stalled).
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_if_done && !i_stall) begin
                if (exp_if.size() == 0) begin
                    chk("if_unexpected_done", 32'(o_if_done), 32'd0);
                end else begin
                    mon_e = exp_if.pop_front();
                    chk("if_rdata", o_if_rdata, mon_e.rdata);
                    chk("if_err", 32'(o_err), 32'(mon_e.err));
                end
            end
            if (o_mem_done && !i_stall) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected_done", 32'(o_mem_done), 32'd0);
                end else begin
                    mon_e = exp_mem.pop_front();
                    chk("mem_rdata", o_mem_rdata, mon_e.rdata);
                    chk("mem_err", 32'(o_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic run_fetch(input int n);
        logic [8:0] idx;
        logic       unm;
        exp_t       x;
        int         t;
        for (int k = 0; k < n; k++) begin
            idx     = 9'($urandom_range(0, 255));
            unm     = ($urandom_range(0, 7) == 0);
            x.rdata = unm ? 32'd0 : ref_mem[idx];
            x.err   = unm;
            exp_if.push_back(x);
            i_if_req  = 1'b1;
            i_if_addr = {20'd0, unm, idx, 2'b00};
            t = 0;
            do begin
                smp();
                t++;
            end while (!(o_if_done && !i_stall) && t < 300);
            chk("fetch_completes", 32'(t < 300), 32'd1);
            cyc();
            i_if_req = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    task automatic run_mem(input int n);
        logic [8:0]  idx;
        logic        unm, we;
        logic [3:0]  sel;
        logic [31:0] wd;
        exp_t        x;
        int          t;
        for (int k = 0; k < n; k++) begin
            idx = 9'(256 + $urandom_range(0, 255));
            unm = ($urandom_range(0, 7) == 0);
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom_range(0, 15));
            wd  = $urandom;
            x.rdata = (unm || we) ? 32'd0 : ref_mem[idx];
            x.err   = unm;
            exp_mem.push_back(x);
            if (!unm && we) ref_mem[idx] = merge(ref_mem[idx], wd, sel);
            i_mem_req   = 1'b1;
            i_mem_we    = we;
            i_mem_sel   = sel;
            i_mem_wdata = wd;
            i_mem_addr  = {20'd0, unm, idx, 2'b00};
            t = 0;
            do begin
                smp();
                t++;
            end while (!(o_mem_done && !i_stall) && t < 300);
            chk("mem_completes", 32'(t < 300), 32'd1);
            cyc();
            i_mem_req = 1'b0;
            repeat ($urandom_range(0, 3)) cyc();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, required finished (tests %0d)", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            slave_mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h3C01_0000;
            ref_mem[i]   = slave_mem[i];
        end
        i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_if_req = 1'b0; i_if_addr = '0;
        i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_sel = '0; i_mem_addr = '0; i_mem_wdata = '0;
        smp();
        chk("rst_bus_req", 32'(o_bus_req), 32'd0);
        chk("rst_dones", 32'({o_if_done, o_mem_done, o_err}), 32'd0);
        chk("rst_bus_addr", o_bus_addr, 32'd0);
        cyc();
        i_rst = 1'b0;

        // Zero-wait fetch: bus_req at cycle 1, done at cycle 2.
        slv_force = 0;
        slave_mem[64] = 32'h3C01_1234;
        ref_mem[64]   = 32'h3C01_1234;
        e.rdata = 32'h3C01_1234; e.err = 1'b0; exp_if.push_back(e);
        cyc(); i_if_req = 1'b1; i_if_addr = 32'h100;
        smp(); chk("t1_streq_c0", 32'(o_if_streq), 32'd1); chk("t1_bus_req_c0", 32'(o_bus_req), 32'd0);
        cyc(); smp();
        chk("t1_bus_req_c1", 32'(o_bus_req), 32'd1); chk("t1_bus_addr", o_bus_addr, 32'h100);
        chk("t1_streq_c1", 32'(o_if_streq), 32'd1);
        cyc(); smp();
        chk("t1_done_c2", 32'(o_if_done), 32'd1); chk("t1_streq_c2", 32'(o_if_streq), 32'd0);
        cyc(); i_if_req = 1'b0;

        // Simultaneous fetch and store: store goes first.
        e.rdata = 32'd0; e.err = 1'b0; exp_mem.push_back(e);
        e.rdata = ref_mem[65]; exp_if.push_back(e);
        ref_mem[0] = merge(ref_mem[0], 32'h0000_DEAD, 4'b0011);
        cyc();
        i_if_req = 1'b1; i_if_addr = 32'h104;
        i_mem_req = 1'b1; i_mem_we = 1'b1; i_mem_sel = 4'b0011; i_mem_addr = 32'h2000;
        i_mem_wdata = 32'h0000_DEAD;
        smp(); chk("t2_streqs_c0", 32'({o_if_streq, o_mem_streq}), 32'd3);
        cyc(); smp();
        chk("t2_bus_we", 32'(o_bus_we), 32'd1); chk("t2_bus_sel", 32'(o_bus_sel), 32'd3);
        chk("t2_bus_addr", o_bus_addr, 32'h2000); chk("t2_bus_wdata", o_bus_wdata, 32'hDEAD);
        cyc(); smp();
        chk("t2_mem_done", 32'(o_mem_done), 32'd1); chk("t2_if_streq_c2", 32'(o_if_streq), 32'd1);
        cyc(); i_mem_req = 1'b0; smp();
        chk("t2_idle_gap", 32'(o_bus_req), 32'd0); chk("t2_if_streq_c3", 32'(o_if_streq), 32'd1);
        cyc(); smp();
        chk("t2_fetch_bus_req", 32'(o_bus_req), 32'd1); chk("t2_fetch_addr", o_bus_addr, 32'h104);
        cyc(); smp(); chk("t2_if_done", 32'(o_if_done), 32'd1);
        cyc(); i_if_req = 1'b0;
        chk("t2_store_merge", slave_mem[0], ref_mem[0]);

        // Load with 5 wait states, result held across 3 stalled cycles.
        slv_force = 5;
        slave_mem[0] = 32'hA5A5_A5A5; ref_mem[0] = 32'hA5A5_A5A5;
        e.rdata = 32'hA5A5_A5A5; e.err = 1'b0; exp_mem.push_back(e);
        cyc();
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_sel = 4'hF; i_mem_addr = 32'h3000; i_stall = 1'b1;
        nreq = 0; found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            smp();
            if (o_bus_req) nreq++;
            if (o_mem_done) found = 1'b1;
            else cyc();
        end
        chk("t3_done_seen", 32'(found), 32'd1); chk("t3_bus_cycles", 32'(nreq), 32'd6);
        for (int c = 0; c < 3; c++) begin
            chk("t3_hold_done", 32'(o_mem_done), 32'd1);
            chk("t3_hold_rdata", o_mem_rdata, 32'hA5A5_A5A5);
            chk("t3_mem_streq", 32'(o_mem_streq), 32'd0);
            cyc();
            if (c == 2) i_stall = 1'b0;
            smp();
        end
        chk("t3_consume_done", 32'(o_mem_done), 32'd1);
        cyc(); i_mem_req = 1'b0; smp();
        chk("t3_idle_after", 32'(o_mem_done), 32'd0);

        // Timeout on an unmapped address.
        e.rdata = 32'd0; e.err = 1'b1; exp_mem.push_back(e);
        cyc(); i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h800;
        nreq = 0; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            smp();
            if (o_bus_req) nreq++;
            if (o_mem_done) found = 1'b1;
            else cyc();
        end
        chk("t4_done_seen", 32'(found), 32'd1); chk("t4_bus_cycles", 32'(nreq), 32'd15);
        chk("t4_err", 32'(o_err), 32'd1); chk("t4_rdata", o_mem_rdata, 32'd0);
        cyc(); i_mem_req = 1'b0;

        // Flush during a fetch bus cycle discards the result.
        slv_force = 3;
        e.rdata = ref_mem[67]; e.err = 1'b0; exp_if.push_back(e);
        cyc(); i_if_req = 1'b1; i_if_addr = 32'h108;
        cyc();
        cyc(); i_flush = 1'b1;
        cyc(); i_flush = 1'b0; i_if_addr = 32'h10C;
        smp(); chk("t5_addr_stable", o_bus_addr, 32'h108);
        ndone = 0;
        cyc(); smp(); ndone += int'(o_if_done); slv_force = 0;
        cyc(); smp(); ndone += int'(o_if_done);
        chk("t5_flush_no_done", 32'(ndone), 32'd0); chk("t5_idle", 32'(o_bus_req), 32'd0);
        cyc(); smp(); chk("t5_regrant_addr", o_bus_addr, 32'h10C);
        cyc(); smp(); chk("t5_regrant_done", 32'(o_if_done), 32'd1);
        cyc(); i_if_req = 1'b0;

        // Flush in IDLE blocks the grant for that cycle only.
        e.rdata = ref_mem[69]; e.err = 1'b0; exp_if.push_back(e);
        cyc(); i_if_req = 1'b1; i_if_addr = 32'h114; i_flush = 1'b1;
        cyc(); i_flush = 1'b0; smp(); chk("t6_flush_blocks", 32'(o_bus_req), 32'd0);
        cyc(); smp(); chk("t6_grant_after", 32'(o_bus_req), 32'd1);
        cyc(); smp(); chk("t6_done", 32'(o_if_done), 32'd1);
        cyc(); i_if_req = 1'b0;

        // Reset mid-transaction abandons the cycle.
        slv_force = 10;
        cyc(); i_if_req = 1'b1; i_if_addr = 32'h110;
        cyc(); smp(); chk("t7_bus_req", 32'(o_bus_req), 32'd1);
        cyc(); i_rst = 1'b1; i_if_req = 1'b0;
        smp();
        chk("t7_rst_bus_req", 32'(o_bus_req), 32'd0);
        chk("t7_rst_outs", 32'({o_if_done, o_mem_done, o_err, o_if_streq}), 32'd0);
        cyc(); i_rst = 1'b0;
        ndone = 0;
        repeat (12) begin smp(); ndone += int'(o_if_done | o_mem_done); cyc(); end
        chk("t7_no_done_after", 32'(ndone), 32'd0);

        // Requester drops mid-transaction: done lasts one cycle despite stall.
        slv_force = 2; i_stall = 1'b1;
        cyc(); i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h404;
        cyc();
        cyc(); i_mem_req = 1'b0;
        ndone = 0;
        repeat (10) begin smp(); ndone += int'(o_mem_done); cyc(); end
        chk("t8_drop_done_cycles", 32'(ndone), 32'd1);
        i_stall = 1'b0;

        // Randomized concurrent traffic with random stalls.
        slv_force = -1;
        fork
            begin
                fork
                    run_fetch(40);
                    run_mem(40);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    cyc();
                    i_stall = ($urandom_range(0, 3) == 0);
                end
                i_stall = 1'b0;
            end
        join
        repeat (5) cyc();
        chk("sb_if_drained", 32'(exp_if.size()), 32'd0);
        chk("sb_mem_drained", 32'(exp_mem.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
